convolution: RTL and testbench

Streaming 3x3 convolution engine: consumes an RGB565 pixel stream plus the coefficient and shift bundle produced by `kernels`, and emits filtered RGB565 pixels. It sits between the camera/frame-buffer read path and the display write path. Internally it holds two line buffers and a 3x3 sliding window, then runs a fixed 4-stage multiply/sum/shift/clamp pipeline.

---
 rtl/convolution_pkg.sv | 47 ++++
 rtl/convolution_line_buffer.sv | 52 +++++
 rtl/convolution.sv | 175 +++++++++++++++++
 tb/tb_convolution.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/convolution_pkg.sv
// Shared types, widths and arithmetic helpers for the streaming 3x3 convolution engine.
package conv_pkg;

  localparam int R_W          = 5;
  localparam int G_W          = 6;
  localparam int B_W          = 5;
  localparam int PIX_W        = R_W + G_W + B_W;
  localparam int TAP_W        = 8;
  localparam int ACC_W        = 16;
  localparam int CONV_LATENCY = 4;

  localparam logic [5:0] R_MAX = 6'd31;
  localparam logic [5:0] G_MAX = 6'd63;
  localparam logic [5:0] B_MAX = 6'd31;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [TAP_W-1:0] tap_t;

  // Channel 0=R, 1=G, 2=B, zero-extended to the widest channel.
  function automatic logic [5:0] chan(input rgb565_t p, input int unsigned c);
    case (c)
      0:       return {1'b0, p.r};
      1:       return p.g;
      default: return {1'b0, p.b};
    endcase
  endfunction

  function automatic acc_t tap_mul(input logic [5:0] d, input tap_t k);
    return acc_t'({{(ACC_W-6){1'b0}}, d}) * acc_t'(k);
  endfunction

  function automatic logic [5:0] clamp_chan(input acc_t v, input logic [5:0] max_v);
    if (v[ACC_W-1])
      return '0;
    else if (v > acc_t'({{(ACC_W-6){1'b0}}, max_v}))
      return max_v;
    else
      return v[5:0];
  endfunction

endpackage

// File: rtl/convolution_line_buffer.sv
// Two-row line buffer with 1-cycle synchronous read; row roles swap at each line start.
module line_buffer
  import conv_pkg::*;
#(
  parameter int H_PIXELS = 320
)
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             data_valid_in,
  input  logic [PIX_W-1:0] pixel_data_in,
  input  logic [10:0]      hcount_in,
  output logic [PIX_W-1:0] prev1_out,
  output logic [PIX_W-1:0] prev2_out
);

  localparam int AW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;

  logic [PIX_W-1:0] row_a [H_PIXELS];
  logic [PIX_W-1:0] row_b [H_PIXELS];
  logic             sel;
  logic             sel_eff;
  logic [AW-1:0]    addr;

  // sel=0: row_a holds the line above, row_b the line two above (overwritten by the live line).
  always_comb begin
    sel_eff = (hcount_in == '0) ? ~sel : sel;
    addr    = hcount_in[AW-1:0];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      sel <= 1'b0;
    else if (data_valid_in)
      sel <= sel_eff;
  end

  always_ff @(posedge clk_in) begin
    if (data_valid_in) begin
      if (sel_eff) begin
        prev1_out   <= row_b[addr];
        prev2_out   <= row_a[addr];
        row_a[addr] <= pixel_data_in;
      end else begin
        prev1_out   <= row_a[addr];
        prev2_out   <= row_b[addr];
        row_b[addr] <= pixel_data_in;
      end
    end
  end

endmodule

// File: rtl/convolution.sv
// Streaming 3x3 convolution on RGB565: window build, products, channel sums, shift/clamp.
module convolution
  import conv_pkg::*;
#(
  parameter int H_PIXELS = 320
)
(
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     data_valid_in,
  input  logic [15:0]              pixel_data_in,
  input  logic [10:0]              hcount_in,
  input  logic [9:0]               vcount_in,
  input  logic signed [2:0][2:0][7:0] coeffs_in,
  input  logic signed [7:0]        shift_in,
  output logic                     data_valid_out,
  output logic [15:0]              pixel_data_out,
  output logic [10:0]              hcount_out,
  output logic [9:0]               vcount_out
);

  logic [PIX_W-1:0] prev1;
  logic [PIX_W-1:0] prev2;

  line_buffer #(.H_PIXELS(H_PIXELS)) u_line_buffer (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .data_valid_in (data_valid_in),
    .pixel_data_in (pixel_data_in),
    .hcount_in     (hcount_in),
    .prev1_out     (prev1),
    .prev2_out     (prev2)
  );

  rgb565_t                     pix_q;
  rgb565_t                     win_l [3];
  rgb565_t                     win_m [3];
  rgb565_t                     win   [3][3];
  logic                        armed;
  logic signed [2:0][2:0][7:0] kern_coeffs;
  logic [2:0]                  kern_shift;
  logic                        shift_unused;

  logic        s0_valid, s1_valid, s2_valid;
  logic [10:0] s0_h, s1_h, s2_h;
  logic [9:0]  s0_v, s1_v, s2_v;
  logic [2:0]  s1_shift, s2_shift;
  acc_t        prod     [3][3][3];
  acc_t        sum      [3];
  acc_t        sum_next [3];
  logic [15:0] pix_next;

  assign shift_unused = ^shift_in[6:3];

  // Right column is the live pixel plus the two rows read this cycle from the line buffer.
  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      win[r][0] = win_l[r];
      win[r][1] = win_m[r];
    end
    win[0][2] = rgb565_t'(prev2);
    win[1][2] = rgb565_t'(prev1);
    win[2][2] = pix_q;
  end

  // S0: window shift, kernel capture at frame start, arming
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pix_q       <= '0;
      armed       <= 1'b0;
      kern_coeffs <= '0;
      kern_shift  <= '0;
      s0_valid    <= 1'b0;
      s0_h        <= '0;
      s0_v        <= '0;
      for (int unsigned r = 0; r < 3; r++) begin
        win_l[r] <= '0;
        win_m[r] <= '0;
      end
    end else begin
      s0_valid <= data_valid_in && armed && (hcount_in >= 11'd2) && (vcount_in >= 10'd2);
      if (data_valid_in) begin
        pix_q <= rgb565_t'(pixel_data_in);
        for (int unsigned r = 0; r < 3; r++) begin
          win_l[r] <= win_m[r];
          win_m[r] <= win[r][2];
        end
        s0_h <= hcount_in - 11'd1;
        s0_v <= vcount_in - 10'd1;
        if (hcount_in == '0 && vcount_in == '0) begin
          armed       <= 1'b1;
          kern_coeffs <= coeffs_in;
          kern_shift  <= shift_in[7] ? 3'd0 : shift_in[2:0];
        end
      end
    end
  end

  // S1: shift amount travels with the products so in-flight pixels keep their frame's kernel.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s1_h     <= '0;
      s1_v     <= '0;
      s1_shift <= '0;
      for (int unsigned ch = 0; ch < 3; ch++)
        for (int unsigned r = 0; r < 3; r++)
          for (int unsigned c = 0; c < 3; c++)
            prod[ch][r][c] <= '0;
    end else begin
      s1_valid <= s0_valid;
      s1_h     <= s0_h;
      s1_v     <= s0_v;
      s1_shift <= kern_shift;
      for (int unsigned ch = 0; ch < 3; ch++)
        for (int unsigned r = 0; r < 3; r++)
          for (int unsigned c = 0; c < 3; c++)
            prod[ch][r][c] <= tap_mul(chan(win[r][c], ch), tap_t'(kern_coeffs[r][c]));
    end
  end

  always_comb begin
    for (int unsigned ch = 0; ch < 3; ch++) begin
      sum_next[ch] = '0;
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          sum_next[ch] = sum_next[ch] + prod[ch][r][c];
    end
  end

  // S2: channel sums
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s2_valid <= 1'b0;
      s2_h     <= '0;
      s2_v     <= '0;
      s2_shift <= '0;
      for (int unsigned ch = 0; ch < 3; ch++)
        sum[ch] <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_h     <= s1_h;
      s2_v     <= s1_v;
      s2_shift <= s1_shift;
      for (int unsigned ch = 0; ch < 3; ch++)
        sum[ch] <= sum_next[ch];
    end
  end

  always_comb begin
    logic [5:0] r_c;
    logic [5:0] g_c;
    logic [5:0] b_c;
    r_c      = clamp_chan(sum[0] >>> s2_shift, R_MAX);
    g_c      = clamp_chan(sum[1] >>> s2_shift, G_MAX);
    b_c      = clamp_chan(sum[2] >>> s2_shift, B_MAX);
    pix_next = {r_c[4:0], g_c, b_c[4:0]};
  end

  // S3: shift, clamp and output registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_valid_out <= 1'b0;
      pixel_data_out <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
    end else begin
      data_valid_out <= s2_valid;
      pixel_data_out <= pix_next;
      hcount_out     <= s2_h;
      vcount_out     <= s2_v;
    end
  end

endmodule

// File: tb/tb_convolution.sv
// Directed bench for convolution on an 8x8 frame: table-driven probes plus latency, gap, kernel-change and reset sequences.
module tb_convolution;

  localparam int H = 8;
  localparam int V = 8;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        dv_in;
  logic [15:0]                 pix_in;
  logic [10:0]                 hc_in;
  logic [9:0]                  vc_in;
  logic signed [2:0][2:0][7:0] coeffs;
  logic signed [7:0]           shift;
  logic                        dv_out;
  logic [15:0]                 pix_out;
  logic [10:0]                 hc_out;
  logic [9:0]                  vc_out;

  convolution #(.H_PIXELS(H)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .data_valid_in  (dv_in),
    .pixel_data_in  (pix_in),
    .hcount_in      (hc_in),
    .vcount_in      (vc_in),
    .coeffs_in      (coeffs),
    .shift_in       (shift),
    .data_valid_out (dv_out),
    .pixel_data_out (pix_out),
    .hcount_out     (hc_out),
    .vcount_out     (vc_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          h;
    int          v;
    logic [15:0] pix;
    int          cyc;
  } out_t;

  out_t out_q[$];
  always @(negedge clk)
    if (dv_out) out_q.push_back('{int'(hc_out), int'(vc_out), pix_out, cyc});

  int in_cyc [H][V];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Images: 0 ramp, 1 flat 0x8410, 2 bright left half, 3 bright right half, 4 single spot at (3,3)
  function automatic logic [15:0] img_pix(input int id, input int x, input int y);
    case (id)
      0:       return 16'(x * 16'h0841 + y * 16'h1004);
      1:       return 16'h8410;
      2:       return (x < 4) ? 16'hFFFF : 16'h0000;
      3:       return (x < 4) ? 16'h0000 : 16'hFFFF;
      default: return (x == 3 && y == 3) ? 16'h0841 : 16'h0000;
    endcase
  endfunction

  // Kernels: 0 identity, 1 gaussian >>4, 2 sobel-x, 3 ridge, 4 gaussian with negative shift
  function automatic logic signed [2:0][2:0][7:0] kern_taps(input int id);
    int t[9];
    logic signed [2:0][2:0][7:0] k;
    case (id)
      0:       t = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
      1, 4:    t = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
      2:       t = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
      default: t = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
    endcase
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        k[r][c] = 8'(t[r * 3 + c]);
    return k;
  endfunction

  function automatic logic signed [7:0] kern_shift(input int id);
    case (id)
      1:       return 8'sd4;
      4:       return -8'sd4;
      default: return 8'sd0;
    endcase
  endfunction

  task automatic drive_range(input int kern, input int img, input int max_gap,
                             input int switch_row, input int switch_kern,
                             input int first, input int last);
    for (int i = first; i <= last; i++) begin
      int x;
      int y;
      int k;
      int gap;
      x   = i % H;
      y   = i / H;
      k   = (y >= switch_row) ? switch_kern : kern;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        dv_in  = 1'b0;
        pix_in = 16'($urandom);
        hc_in  = '0;
        vc_in  = '0;
        coeffs = kern_taps(3);
        shift  = 8'sd1;
        @(posedge clk); #1;
      end
      coeffs    = kern_taps(k);
      shift     = kern_shift(k);
      dv_in     = 1'b1;
      pix_in    = img_pix(img, x, y);
      hc_in     = 11'(x);
      vc_in     = 10'(y);
      in_cyc[x][y] = cyc;
      @(posedge clk); #1;
    end
    dv_in = 1'b0;
  endtask

  task automatic run_frame(input int kern, input int img, input int max_gap,
                           input int switch_row, input int switch_kern);
    out_q.delete();
    drive_range(kern, img, max_gap, switch_row, switch_kern, 0, H * V - 1);
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Identity on the ramp: every interior pixel, in raster order, exactly 4 cycles after its completing input.
  task automatic check_identity_frame(input string tag);
    int n;
    check({tag, "_count"}, out_q.size(), 36);
    n = (out_q.size() < 36) ? out_q.size() : 36;
    for (int k = 0; k < n; k++) begin
      int x;
      int y;
      x = 1 + k % 6;
      y = 1 + k / 6;
      check($sformatf("%s_h%0d", tag, k), out_q[k].h, x);
      check($sformatf("%s_v%0d", tag, k), out_q[k].v, y);
      check($sformatf("%s_pix(%0d,%0d)", tag, x, y), out_q[k].pix, img_pix(0, x, y));
      check($sformatf("%s_lat(%0d,%0d)", tag, x, y), out_q[k].cyc - in_cyc[x + 1][y + 1], 4);
    end
  endtask

  function automatic logic [31:0] probe(input int x, input int y);
    foreach (out_q[k])
      if (out_q[k].h == x && out_q[k].v == y) return {16'h0, out_q[k].pix};
    return 32'hFFFF_FFFF;
  endfunction

  typedef struct {
    int          kern;
    int          img;
    int          x;
    int          y;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int cur_k;
    int cur_i;

    vecs.push_back('{0, 0, 1, 1, 16'h1845});
    vecs.push_back('{0, 0, 3, 4, 16'h58D3});
    vecs.push_back('{0, 0, 6, 6, 16'h919E});
    vecs.push_back('{1, 1, 1, 1, 16'h8410});
    vecs.push_back('{1, 1, 4, 5, 16'h8410});
    vecs.push_back('{1, 1, 6, 6, 16'h8410});
    vecs.push_back('{2, 2, 3, 3, 16'h0000});
    vecs.push_back('{2, 2, 4, 4, 16'h0000});
    vecs.push_back('{2, 3, 3, 3, 16'hFFFF});
    vecs.push_back('{2, 3, 4, 2, 16'hFFFF});
    vecs.push_back('{2, 3, 1, 1, 16'h0000});
    vecs.push_back('{2, 3, 6, 6, 16'h0000});
    vecs.push_back('{4, 1, 2, 2, 16'hFFFF});
    vecs.push_back('{3, 4, 3, 3, 16'h4208});
    vecs.push_back('{3, 4, 2, 3, 16'h0000});
    vecs.push_back('{3, 4, 4, 4, 16'h0000});

    rst    = 1'b1;
    dv_in  = 1'b0;
    pix_in = '0;
    hc_in  = '0;
    vc_in  = '0;
    coeffs = '0;
    shift  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", dv_out, 0);
    check("rst_pixel", pix_out, 0);
    check("rst_hcount", hc_out, 0);
    check("rst_vcount", vc_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(0, 0, 0, 99, 0);
    check_identity_frame("ident");

    run_frame(0, 0, 5, 99, 0);
    check_identity_frame("gaps");

    cur_k = -1;
    cur_i = -1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].kern != cur_k || vecs[i].img != cur_i) begin
        run_frame(vecs[i].kern, vecs[i].img, 0, 99, 0);
        cur_k = vecs[i].kern;
        cur_i = vecs[i].img;
      end
      check($sformatf("vec%0d_k%0d_i%0d(%0d,%0d)", i, vecs[i].kern, vecs[i].img, vecs[i].x, vecs[i].y),
            probe(vecs[i].x, vecs[i].y), {16'h0, vecs[i].exp});
    end

    // Ridge taps presented from row 3 on must not disturb this frame
    run_frame(0, 0, 0, 3, 3);
    check_identity_frame("midchg");
    run_frame(3, 4, 0, 99, 3);
    check("next_frame_ridge_centre", probe(3, 3), 32'h4208);
    check("next_frame_ridge_side", probe(2, 3), 32'h0000);

    // Reset at row 5 while an output is being presented
    out_q.delete();
    drive_range(0, 0, 0, 99, 0, 0, 5 * H + 5);
    check("pre_rst_valid", dv_out, 1);
    check("pre_rst_hcount", hc_out, 1);
    check("pre_rst_vcount", vc_out, 4);
    rst = 1'b1;
    #1;
    check("midrst_valid", dv_out, 0);
    check("midrst_pixel", pix_out, 0);
    check("midrst_hcount", hc_out, 0);
    check("midrst_vcount", vc_out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_q.delete();
    drive_range(0, 0, 0, 99, 0, 5 * H + 6, H * V - 1);
    repeat (8) @(posedge clk);
    #1;
    check("unarmed_outputs", out_q.size(), 0);

    run_frame(0, 0, 0, 99, 0);
    check("rearm_count", out_q.size(), 36);
    if (out_q.size() > 0) begin
      check("rearm_first_h", out_q[0].h, 1);
      check("rearm_first_v", out_q[0].v, 1);
      check("rearm_first_pix", out_q[0].pix, img_pix(0, 1, 1));
    end else begin
      check("rearm_first_present", 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
